mem_port_arbiter: RTL and testbench

- Shares the single AXI_master_SRAM user interface (one RREQ/WREQ port) between two requesters: the instruction fetch unit (port IF, read-only) and the EXU load/store path (port LS, read and write).
- Sits between IFU/EXU and the AXI master.
- Captures one-cycle request pulses into per-port pending buffers, grants one transaction at a time, and returns a one-cycle ack with read data to the owner.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one SRAM-style request port between the IFU (read) and LSU (read/write).
// Define RR_ARB_EN for IF/LS round-robin; otherwise fixed priority LS_WR > LS_RD > IF_RD.
module mem_port_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_rreq,
    input  logic [AW-1:0]   if_raddr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            ls_rreq,
    input  logic [AW-1:0]   ls_raddr,
    input  logic            ls_wreq,
    input  logic [AW-1:0]   ls_waddr,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_wmask,
    output logic [DW-1:0]   ls_rdata,
    output logic            ls_ack,
    output logic            dn_rreq,
    output logic [AW-1:0]   dn_raddr,
    output logic            dn_wreq,
    output logic [AW-1:0]   dn_waddr,
    output logic [DW-1:0]   dn_wdata,
    output logic [DW/8-1:0] dn_wmask,
    input  logic [DW-1:0]   dn_rdata,
    input  logic            dn_rack,
    input  logic            dn_wack,
    output logic            busy,
    output logic            proto_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {G_IF, G_LR, G_LW} grant_t;

    state_t state, state_nxt;
    grant_t gnt, sel;

    logic            if_pend, lr_pend, lw_pend;
    logic [AW-1:0]   if_addr_q, lr_addr_q, lw_addr_q;
    logic [DW-1:0]   lw_data_q;
    logic [DW/8-1:0] lw_mask_q;

    logic dn_done, any_pend;
    logic clr_if, clr_lr, clr_lw;
    logic drop_if, drop_lr, drop_lw;

    // Only the ack type matching the current grant completes it; the other is ignored.
    assign dn_done  = (state == ISSUE || state == WAIT) &&
                      ((gnt == G_LW) ? dn_wack : dn_rack);
    assign any_pend = if_pend | lr_pend | lw_pend;

    assign clr_if = dn_done && (gnt == G_IF);
    assign clr_lr = dn_done && (gnt == G_LR);
    assign clr_lw = dn_done && (gnt == G_LW);

    // A slot being freed this cycle may accept a fresh request without error.
    assign drop_if = if_rreq && if_pend && !clr_if;
    assign drop_lr = ls_rreq && lr_pend && !clr_lr;
    assign drop_lw = ls_wreq && lw_pend && !clr_lw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pend   <= 1'b0;
            lr_pend   <= 1'b0;
            lw_pend   <= 1'b0;
            if_addr_q <= '0;
            lr_addr_q <= '0;
            lw_addr_q <= '0;
            lw_data_q <= '0;
            lw_mask_q <= '0;
            proto_err <= 1'b0;
        end else begin
            if (clr_if) if_pend <= 1'b0;
            if (clr_lr) lr_pend <= 1'b0;
            if (clr_lw) lw_pend <= 1'b0;
            if (if_rreq && !drop_if) begin
                if_pend   <= 1'b1;
                if_addr_q <= if_raddr;
            end
            if (ls_rreq && !drop_lr) begin
                lr_pend   <= 1'b1;
                lr_addr_q <= ls_raddr;
            end
            if (ls_wreq && !drop_lw) begin
                lw_pend   <= 1'b1;
                lw_addr_q <= ls_waddr;
                lw_data_q <= ls_wdata;
                lw_mask_q <= ls_wmask;
            end
            if (drop_if || drop_lr || drop_lw) proto_err <= 1'b1;
        end
    end

`ifdef RR_ARB_EN
    logic last_owner;  // 0: IF group served last, 1: LS group

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_owner <= 1'b0;
        else if (state == DONE)
            last_owner <= (gnt != G_IF);
    end

    always_comb begin
        sel = G_IF;
        if ((lw_pend || lr_pend) && (!if_pend || !last_owner))
            sel = lw_pend ? G_LW : G_LR;
    end
`else
    always_comb begin
        sel = G_IF;
        if (lw_pend)
            sel = G_LW;
        else if (lr_pend)
            sel = G_LR;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_pend) state_nxt = ISSUE;
            ISSUE:   state_nxt = dn_done ? DONE : WAIT;
            WAIT:    if (dn_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= G_IF;
            dn_raddr <= '0;
            dn_waddr <= '0;
            dn_wdata <= '0;
            dn_wmask <= '0;
            if_rdata <= '0;
            ls_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_pend) begin
                gnt <= sel;
                case (sel)
                    G_LW: begin
                        dn_waddr <= lw_addr_q;
                        dn_wdata <= lw_data_q;
                        dn_wmask <= lw_mask_q;
                    end
                    G_LR:    dn_raddr <= lr_addr_q;
                    default: dn_raddr <= if_addr_q;
                endcase
            end
            if (clr_if) if_rdata <= dn_rdata;
            if (clr_lr) ls_rdata <= dn_rdata;
        end
    end

    assign dn_rreq = (state == ISSUE) && (gnt != G_LW);
    assign dn_wreq = (state == ISSUE) && (gnt == G_LW);
    assign busy    = (state == ISSUE) || (state == WAIT);
    assign if_ack  = (state == DONE) && (gnt == G_IF);
    assign ls_ack  = (state == DONE) && (gnt != G_IF);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected downstream requests and
// owner acks, a responder plays the AXI master, and a monitor compares at the falling edge.
module tb_mem_port_arbiter;
    logic        clk;
    logic        rst_n;
    logic        if_rreq;
    logic [63:0] if_raddr;
    logic [63:0] if_rdata;
    logic        if_ack;
    logic        ls_rreq;
    logic [63:0] ls_raddr;
    logic        ls_wreq;
    logic [63:0] ls_waddr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic [63:0] ls_rdata;
    logic        ls_ack;
    logic        dn_rreq;
    logic [63:0] dn_raddr;
    logic        dn_wreq;
    logic [63:0] dn_waddr;
    logic [63:0] dn_wdata;
    logic [7:0]  dn_wmask;
    logic [63:0] dn_rdata;
    logic        dn_rack;
    logic        dn_wack;
    logic        busy;
    logic        proto_err;

    mem_port_arbiter #(.AW(64), .DW(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_rreq(if_rreq), .if_raddr(if_raddr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_rreq(ls_rreq), .ls_raddr(ls_raddr), .ls_wreq(ls_wreq), .ls_waddr(ls_waddr),
        .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .dn_rreq(dn_rreq), .dn_raddr(dn_raddr), .dn_wreq(dn_wreq), .dn_waddr(dn_waddr),
        .dn_wdata(dn_wdata), .dn_wmask(dn_wmask), .dn_rdata(dn_rdata),
        .dn_rack(dn_rack), .dn_wack(dn_wack), .busy(busy), .proto_err(proto_err)
    );

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
        int          cyc;
    } dn_exp_t;

    typedef struct {
        int          lat;
        logic [63:0] data;
    } resp_t;

    dn_exp_t     dn_q[$];
    resp_t       resp_q[$];
    logic [63:0] if_q[$];
    logic [63:0] ls_q[$];
    int          ackc_q[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] model_ls;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dn(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] mask, input int c);
        dn_exp_t e;
        e.wr = wr; e.addr = addr; e.data = data; e.mask = mask; e.cyc = c;
        dn_q.push_back(e);
    endtask

    task automatic push_resp(input int lat, input logic [63:0] data);
        resp_t r;
        r.lat = lat; r.data = data;
        resp_q.push_back(r);
    endtask

    // One-cycle pulse of the selected request lines, starting in the current cycle.
    task automatic apply_stimulus(input logic ifr, input logic [63:0] ifa,
                                  input logic lrr, input logic [63:0] lra,
                                  input logic lwr, input logic [63:0] lwa,
                                  input logic [63:0] lwd, input logic [7:0] lwm);
        if_rreq = ifr; if_raddr = ifa;
        ls_rreq = lrr; ls_raddr = lra;
        ls_wreq = lwr; ls_waddr = lwa; ls_wdata = lwd; ls_wmask = lwm;
        tick();
        if_rreq = 1'b0; ls_rreq = 1'b0; ls_wreq = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (k < 300 && !(dn_q.size() == 0 && if_q.size() == 0 && ls_q.size() == 0 &&
                            resp_q.size() == 0 && !busy && !if_ack && !ls_ack)) begin
            tick();
            k++;
        end
        if (k >= 300) check_output({name, "_timeout"}, 64'd1, 64'd0);
        repeat (2) tick();
    endtask

    // Downstream responder: acks each request after the queued latency (0 = in the ISSUE cycle).
    initial begin
        resp_t r;
        int    issue_c;
        logic  wr;
        logic  abandoned;
        dn_rack = 1'b0; dn_wack = 1'b0; dn_rdata = '0;
        forever begin
            @(negedge clk);
            if (dn_rreq || dn_wreq) begin
                issue_c = cyc;
                wr = dn_wreq;
                abandoned = 1'b0;
                if (resp_q.size() == 0) begin
                    r.lat = 1; r.data = '0;
                end else begin
                    r = resp_q.pop_front();
                end
                if (r.lat > 0) begin
                    repeat (r.lat) begin
                        @(posedge clk);
                        if (!rst_n) abandoned = 1'b1;
                    end
                    #1;
                end
                dn_rdata = r.data;
                if (wr) dn_wack = 1'b1;
                else    dn_rack = 1'b1;
                if (!abandoned) ackc_q.push_back(issue_c + r.lat + 1);
                @(posedge clk);
                #1;
                dn_rack = 1'b0; dn_wack = 1'b0;
            end
        end
    end

    // Monitor: every downstream request and owner ack is popped against the scoreboard.
    initial begin
        dn_exp_t e;
        int      c;
        forever begin
            @(negedge clk);
            if (dn_rreq || dn_wreq) begin
                check_output("dn_req_onehot", 64'(dn_rreq && dn_wreq), 64'd0);
                if (dn_q.size() == 0) begin
                    check_output("dn_unexpected_req", 64'd1, 64'd0);
                end else begin
                    e = dn_q.pop_front();
                    check_output("dn_is_write", 64'(dn_wreq), 64'(e.wr));
                    if (e.wr) begin
                        check_output("dn_waddr", dn_waddr, e.addr);
                        check_output("dn_wdata", dn_wdata, e.data);
                        check_output("dn_wmask", 64'(dn_wmask), 64'(e.mask));
                    end else begin
                        check_output("dn_raddr", dn_raddr, e.addr);
                    end
                    if (e.cyc >= 0) check_output("dn_issue_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (if_ack || ls_ack) begin
                check_output("ack_onehot", 64'(if_ack && ls_ack), 64'd0);
                if (ackc_q.size() == 0) begin
                    check_output("ack_unexpected_timing", 64'd1, 64'd0);
                end else begin
                    c = ackc_q.pop_front();
                    check_output("ack_cycle", 64'(cyc), 64'(c));
                end
            end
            if (if_ack) begin
                if (if_q.size() == 0) check_output("if_ack_unexpected", 64'd1, 64'd0);
                else check_output("if_rdata", if_rdata, if_q.pop_front());
            end
            if (ls_ack) begin
                if (ls_q.size() == 0) check_output("ls_ack_unexpected", 64'd1, 64'd0);
                else check_output("ls_rdata", ls_rdata, ls_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] d;
        int          lat;
        int          k;
        rst_n = 1'b0;
        if_rreq = 1'b0; if_raddr = '0;
        ls_rreq = 1'b0; ls_raddr = '0;
        ls_wreq = 1'b0; ls_waddr = '0; ls_wdata = '0; ls_wmask = '0;
        model_ls = '0;

        #2;
        check_output("reset_req", {62'd0, dn_rreq, dn_wreq}, 64'd0);
        check_output("reset_acks_busy_err", {61'd0, if_ack, ls_ack, busy | proto_err}, 64'd0);
        check_output("reset_dn_raddr", dn_raddr, 64'd0);
        check_output("reset_rdata", if_rdata | ls_rdata, 64'd0);
        #10 rst_n = 1'b1;
        tick();

        $display("[TB] single IF read");
        push_resp(3, 64'h13);
        push_dn(1'b0, 64'h8000_0000, '0, '0, 4);
        if_q.push_back(64'h13);
        apply_stimulus(1'b1, 64'h8000_0000, 1'b0, '0, 1'b0, '0, '0, '0);
        wait_idle("single_if");

        $display("[TB] IF read vs LS write contention");
        push_resp(2, 64'h0);
        push_resp(1, 64'hCAFE);
        push_dn(1'b1, 64'h8000_1000, 64'hDEAD, 8'h0F, -1);
        push_dn(1'b0, 64'h8000_0040, '0, '0, -1);
        ls_q.push_back(model_ls);
        if_q.push_back(64'hCAFE);
        apply_stimulus(1'b1, 64'h8000_0040, 1'b0, '0, 1'b1, 64'h8000_1000, 64'hDEAD, 8'h0F);
        wait_idle("contention");

        $display("[TB] LS read and write in the same cycle");
        push_resp(1, 64'h0);
        push_resp(2, 64'h1234_5678_9ABC_DEF0);
        push_dn(1'b1, 64'h8000_2000, 64'h55AA, 8'hFF, -1);
        push_dn(1'b0, 64'h8000_2008, '0, '0, -1);
        ls_q.push_back(model_ls);
        model_ls = 64'h1234_5678_9ABC_DEF0;
        ls_q.push_back(model_ls);
        apply_stimulus(1'b0, '0, 1'b1, 64'h8000_2008, 1'b1, 64'h8000_2000, 64'h55AA, 8'hFF);
        wait_idle("ls_rw");

        $display("[TB] duplicate IF request while pending");
        check_output("proto_err_clear_before", 64'(proto_err), 64'd0);
        push_resp(3, 64'h77);
        push_dn(1'b0, 64'h0, '0, '0, -1);
        if_q.push_back(64'h77);
        apply_stimulus(1'b1, 64'h0, 1'b0, '0, 1'b0, '0, '0, '0);
        apply_stimulus(1'b1, 64'h4, 1'b0, '0, 1'b0, '0, '0, '0);
        tick();
        check_output("proto_err_set", 64'(proto_err), 64'd1);
        wait_idle("proto");
        check_output("proto_err_sticky", 64'(proto_err), 64'd1);

        $display("[TB] async reset during WAIT");
        push_resp(6, 64'h99);
        push_dn(1'b0, 64'h100, '0, '0, -1);
        apply_stimulus(1'b1, 64'h100, 1'b0, '0, 1'b0, '0, '0, '0);
        repeat (3) tick();
        check_output("busy_in_wait", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_busy_err", {62'd0, busy, proto_err}, 64'd0);
        check_output("rst_dn_raddr", dn_raddr, 64'd0);
        check_output("rst_rdata", if_rdata | ls_rdata, 64'd0);
        tick();
        rst_n = 1'b1;
        model_ls = '0;
        repeat (8) tick();
        check_output("post_rst_idle", {62'd0, busy, dn_rreq}, 64'd0);
        wait_idle("reset");

        $display("[TB] back-to-back IF reads with random latency");
        for (int i = 0; i < 100; i++) begin
            lat = (i == 0) ? 0 : int'($urandom_range(0, 4));
            d = {$urandom(), $urandom()};
            push_resp(lat, d);
            push_dn(1'b0, 64'h9000_0000 + 64'(i * 8), '0, '0, -1);
            if_q.push_back(d);
            apply_stimulus(1'b1, 64'h9000_0000 + 64'(i * 8), 1'b0, '0, 1'b0, '0, '0, '0);
            k = 0;
            while (!if_ack && k < 50) begin
                tick();
                k++;
            end
            if (k >= 50) check_output("b2b_ack_timeout", 64'd1, 64'd0);
        end
        wait_idle("b2b");
        check_output("b2b_no_proto_err", 64'(proto_err), 64'd0);
        check_output("left_dn", 64'(dn_q.size()), 64'd0);
        check_output("left_if", 64'(if_q.size()), 64'd0);
        check_output("left_ls", 64'(ls_q.size()), 64'd0);
        check_output("left_ack_timing", 64'(ackc_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
